// File: rtl/lifo_stack_param_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : lifo_stack_param_if
// Brief    : Request/response and status bundle for the parametrised LIFO.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface lifo_stack_param_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             clr;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] dataOut;
  logic             outValid;
  logic [WIDTH-1:0] topData;
  logic [CW-1:0]    count;
  logic             EMPTY;
  logic             FULL;
  logic             ALMOST_FULL;
  logic             OVF;
  logic             UNF;

  modport master (
    output clr, push, pop, dataIn,
    input  dataOut, outValid, topData, count, EMPTY, FULL, ALMOST_FULL, OVF, UNF
  );

  modport slave (
    input  clr, push, pop, dataIn,
    output dataOut, outValid, topData, count, EMPTY, FULL, ALMOST_FULL, OVF, UNF
  );
endinterface
`default_nettype wire

// File: rtl/lifo_stack_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : lifo_stack_param
// Brief    : Parametrised LIFO with replace-top, pass-through, peek and
//            sticky overflow/underflow flags.
// Revision : 1.0
// ---------------------------------------------------------------------------
module lifo_stack_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  wire logic          Clk,
  input  wire logic          Rst,
  lifo_stack_param_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);
  localparam logic [CW-1:0] c_af    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] c_one   = CW'(1);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             r_ovf;
  logic             r_unf;

  logic             w_empty;
  logic             w_full;
  logic [CW-1:0]    w_cnt_m1;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_push_idx;
  logic [WIDTH-1:0] w_top;
  logic             w_wr_en;
  logic [AW-1:0]    w_wr_idx;

  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == c_depth);
  assign w_cnt_m1   = r_cnt - c_one;
  assign w_top_idx  = w_cnt_m1[AW-1:0];
  assign w_push_idx = r_cnt[AW-1:0];
  assign w_top      = r_mem[w_top_idx];

  // Plain push needs room; push+pop overwrites the current top in place.
  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_idx = w_push_idx;
    if (!bus.clr && bus.push) begin
      if (bus.pop && !w_empty) begin
        w_wr_en  = 1'b1;
        w_wr_idx = w_top_idx;
      end else if (!bus.pop && !w_full) begin
        w_wr_en  = 1'b1;
      end
    end
  end

  // Storage is not reset, but a write coinciding with reset must not land.
  always_ff @(posedge Clk) begin
    if (Rst && w_wr_en) begin
      r_mem[w_wr_idx] <= bus.dataIn;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_cnt   <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (bus.clr) begin
      r_cnt   <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case ({bus.push, bus.pop})
        2'b10: begin
          if (!w_full) r_cnt <= r_cnt + c_one;
          else         r_ovf <= 1'b1;
        end
        2'b01: begin
          if (!w_empty) begin
            r_dout  <= w_top;
            r_valid <= 1'b1;
            r_cnt   <= w_cnt_m1;
          end else begin
            r_unf   <= 1'b1;
          end
        end
        2'b11: begin
          r_dout  <= w_empty ? bus.dataIn : w_top;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.dataOut     = r_dout;
  assign bus.outValid    = r_valid;
  assign bus.topData     = w_empty ? '0 : w_top;
  assign bus.count       = r_cnt;
  assign bus.EMPTY       = w_empty;
  assign bus.FULL        = w_full;
  assign bus.ALMOST_FULL = (r_cnt >= c_af);
  assign bus.OVF         = r_ovf;
  assign bus.UNF         = r_unf;
endmodule
`default_nettype wire

// File: tb/tb_lifo_stack_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_lifo_stack_param
// Brief    : Directed scoreboard bench for lifo_stack_param (16x4, AF at 3).
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_lifo_stack_param;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  lifo_stack_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  lifo_stack_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every outValid pulse must match the oldest expected pop word.
  always @(negedge Clk) begin
    if (Rst && bus.outValid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_outValid: dataOut 0x%0h with no expected pop", bus.dataOut);
      end else begin
        chk("pop_data", 32'(bus.dataOut), 32'(sb.pop_front()));
      end
    end
  end

  // One operation per rising edge; inputs change on the falling edge.
  task automatic op(input logic p, input logic q, input logic [WIDTH-1:0] d,
                    input logic exp_v, input logic [WIDTH-1:0] exp_d);
    @(negedge Clk);
    bus.push   = p;
    bus.pop    = q;
    bus.dataIn = d;
    if (exp_v) sb.push_back(exp_d);
    @(posedge Clk);
    #2;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge Clk);
    bus.clr = 1'b1;
    @(posedge Clk);
    #2;
    bus.clr = 1'b0;
  endtask

  task automatic chk_status(input string tag, input int cnt, input logic [WIDTH-1:0] top,
                            input logic ovf, input logic unf);
    chk({tag, "_count"}, 32'(bus.count), 32'(cnt));
    chk({tag, "_top"},   32'(bus.topData), 32'(top));
    chk({tag, "_empty"}, 32'(bus.EMPTY), 32'(cnt == 0));
    chk({tag, "_full"},  32'(bus.FULL), 32'(cnt == DEPTH));
    chk({tag, "_af"},    32'(bus.ALMOST_FULL), 32'(cnt >= AF));
    chk({tag, "_ovf"},   32'(bus.OVF), 32'(ovf));
    chk({tag, "_unf"},   32'(bus.UNF), 32'(unf));
  endtask

  task automatic chk_reset(input string tag);
    chk_status(tag, 0, 16'h0000, 1'b0, 1'b0);
    chk({tag, "_valid"}, 32'(bus.outValid), 32'd0);
    chk({tag, "_dout"},  32'(bus.dataOut), 32'd0);
  endtask

  logic [WIDTH-1:0] fill [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  initial begin
    bus.clr = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.dataIn = '0;
    repeat (3) @(posedge Clk);
    #2 Rst = 1'b1;
    chk_reset("reset");

    // Push then flush.
    op(1, 0, 16'h00A1, 0, 0);
    chk_status("push_a1", 1, 16'h00A1, 0, 0);
    do_clr();
    chk_status("clr", 0, 16'h0000, 0, 0);

    // Fill and drain.
    for (int i = 0; i < 4; i++) begin
      op(1, 0, fill[i], 0, 0);
      chk_status("fill", i + 1, fill[i], 0, 0);
    end
    for (int i = 3; i >= 0; i--) begin
      op(0, 1, 0, 1, fill[i]);
      chk("drain_valid", 32'(bus.outValid), 32'd1);
      chk_status("drain", i, (i == 0) ? 16'h0000 : fill[i-1], 0, 0);
    end

    // Replace at FULL, overflow, drain, underflow.
    for (int i = 0; i < 4; i++) op(1, 0, fill[i], 0, 0);
    op(1, 1, 16'h9999, 1, 16'h4444);
    chk_status("replace_full", 4, 16'h9999, 0, 0);
    op(1, 0, 16'h5555, 0, 0);
    chk_status("overflow", 4, 16'h9999, 1, 0);
    op(0, 1, 0, 1, 16'h9999);
    op(0, 1, 0, 1, 16'h3333);
    op(0, 1, 0, 1, 16'h2222);
    op(0, 1, 0, 1, 16'h1111);
    chk_status("drained", 0, 16'h0000, 1, 0);
    op(0, 1, 0, 0, 0);
    chk("underflow_valid", 32'(bus.outValid), 32'd0);
    chk("underflow_dout_hold", 32'(bus.dataOut), 32'h1111);
    chk_status("underflow", 0, 16'h0000, 1, 1);
    do_clr();
    chk_reset("clr_flags");

    // Replace-top at depth 2.
    op(1, 0, 16'h1111, 0, 0);
    op(1, 0, 16'h2222, 0, 0);
    op(1, 1, 16'h9999, 1, 16'h2222);
    chk("replace_valid", 32'(bus.outValid), 32'd1);
    chk_status("replace2", 2, 16'h9999, 0, 0);
    op(0, 1, 0, 1, 16'h9999);
    op(0, 1, 0, 1, 16'h1111);

    // Pass-through on empty.
    op(1, 1, 16'h7777, 1, 16'h7777);
    chk("pass_valid", 32'(bus.outValid), 32'd1);
    chk_status("pass", 0, 16'h0000, 0, 0);
    op(0, 0, 0, 0, 0);
    chk("idle_valid", 32'(bus.outValid), 32'd0);

    // Async reset mid-burst, held across an edge carrying a push.
    op(1, 0, 16'hA001, 0, 0);
    op(1, 0, 16'hA002, 0, 0);
    chk_status("pre_rst", 2, 16'hA002, 0, 0);
    @(negedge Clk);
    bus.push = 1'b1; bus.dataIn = 16'hBEEF;
    #2 Rst = 1'b0;
    #1 chk_reset("async_rst");
    @(posedge Clk);
    #2 bus.push = 1'b0;
    chk_reset("rst_held");
    #1 Rst = 1'b1;
    op(1, 0, 16'hC0DE, 0, 0);
    chk_status("post_rst", 1, 16'hC0DE, 0, 0);

    repeat (2) @(posedge Clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
`default_nettype wire
